// File: rtl/div_issue_unit.sv
// Front end between the EXU and the iterative divider for RISC-V M-extension div/rem ops.
// Define DIV_RESULT_CACHE_EN to add a one-entry cache of the last divider result.
module div_issue_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      div_op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            div_valid,
  input  logic            div_ready,
  output logic            div_flush,
  output logic            div_divw,
  output logic            div_signed,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  input  logic            div_out_valid,
  input  logic [XLEN-1:0] div_quotient,
  input  logic [XLEN-1:0] div_remainder
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state, state_nxt;
  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q, b_q, res_q;
  logic            accept, div_zero, sovf, special, hit, capture;
  logic [XLEN-1:0] spec_res, hit_res;

  // Select quotient or remainder; every W result is sign-extended from bit 31.
  function automatic logic [XLEN-1:0] pick(input logic rem, input logic word,
                                           input logic [XLEN-1:0] quo,
                                           input logic [XLEN-1:0] rmd);
    logic [XLEN-1:0] raw;
    raw = rem ? rmd : quo;
    return word ? {{(XLEN-32){raw[31]}}, raw[31:0]} : raw;
  endfunction

  always_comb begin
    accept   = (state == IDLE) && in_valid && !flush;
    div_zero = div_op[2] ? (src2[31:0] == '0) : (src2 == '0);
    sovf     = !div_op[0] &&
               (div_op[2] ? (src1[31:0] == 32'h8000_0000 && src2[31:0] == '1)
                          : (src1 == {1'b1, {(XLEN-1){1'b0}}} && src2 == '1));
    special  = div_zero || sovf;
    // Feeding src1 through pick() covers both the 64-bit and W special results.
    spec_res = pick(div_op[1], div_op[2],
                    div_zero ? {XLEN{1'b1}} : src1,
                    div_zero ? src1 : {XLEN{1'b0}});
    capture  = (state == WAIT) && div_out_valid && !flush;
  end

`ifdef DIV_RESULT_CACHE_EN
  logic            c_valid, c_uns, c_word;
  logic [XLEN-1:0] c_a, c_b, c_q, c_r;

  assign hit     = c_valid && (c_a == src1) && (c_b == src2) &&
                   (c_uns == div_op[0]) && (c_word == div_op[2]);
  assign hit_res = pick(div_op[1], div_op[2], c_q, c_r);

  always_ff @(posedge clk) begin
    if (rst) begin
      c_valid <= 1'b0;
      c_uns   <= 1'b0;
      c_word  <= 1'b0;
      c_a     <= '0;
      c_b     <= '0;
      c_q     <= '0;
      c_r     <= '0;
    end else if (capture) begin
      c_valid <= 1'b1;
      c_uns   <= op_q[0];
      c_word  <= op_q[2];
      c_a     <= a_q;
      c_b     <= b_q;
      c_q     <= div_quotient;
      c_r     <= div_remainder;
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    div_valid = 1'b0;
    div_flush = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !flush;
        if (accept) state_nxt = (special || hit) ? DONE : ISSUE;
      end
      ISSUE: begin
        div_valid = !flush;
        if (flush)          state_nxt = IDLE;
        else if (div_ready) state_nxt = WAIT;
      end
      WAIT: begin
        div_flush = flush;
        if (flush)              state_nxt = IDLE;
        else if (div_out_valid) state_nxt = DONE;
      end
      DONE: begin
        if (flush || out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q <= div_op;
        a_q  <= src1;
        b_q  <= src2;
        if (special)  res_q <= spec_res;
        else if (hit) res_q <= hit_res;
      end
      if (capture) res_q <= pick(op_q[1], op_q[2], div_quotient, div_remainder);
    end
  end

  assign out_valid    = (state == DONE);
  assign result       = res_q;
  assign div_dividend = a_q;
  assign div_divisor  = b_q;
  assign div_divw     = op_q[2];
  assign div_signed   = !op_q[0];

endmodule

// File: tb/tb_div_issue_unit.sv
// Self-checking bench for div_issue_unit: vector table, random ops and flush/hold sequences
// against a behavioural divider; cache-dependent expectations follow DIV_RESULT_CACHE_EN.
module tb_div_issue_unit;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic        div_valid, div_ready, div_flush, div_divw, div_signed, div_out_valid;
  logic [2:0]  div_op;
  logic [63:0] src1, src2, result, div_dividend, div_divisor, div_quotient, div_remainder;

  always #5 clk = ~clk;

  div_issue_unit #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .div_op(div_op),
    .src1(src1), .src2(src2), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .div_valid(div_valid), .div_ready(div_ready), .div_flush(div_flush),
    .div_divw(div_divw), .div_signed(div_signed), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_out_valid(div_out_valid), .div_quotient(div_quotient),
    .div_remainder(div_remainder)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] sbq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // RISC-V divide semantics; W returns zero-extended 32-bit values like the divider does.
  function automatic logic [63:0] raw(input logic s, input logic w, input logic [63:0] a,
                                      input logic [63:0] b, input logic want_rem);
    logic [31:0] a32, b32, q32, r32;
    logic [63:0] q, r;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      if (b32 == 32'h0) begin q32 = 32'hFFFF_FFFF; r32 = a32; end
      else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin q32 = a32; r32 = 32'h0; end
      else if (s) begin q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32); end
      else begin q32 = a32 / b32; r32 = a32 % b32; end
      q = {32'h0, q32};
      r = {32'h0, r32};
    end else begin
      if (b == 64'h0) begin q = 64'hFFFF_FFFF_FFFF_FFFF; r = a; end
      else if (s && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin q = a; r = 64'h0; end
      else if (s) begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
      else begin q = a / b; r = a % b; end
    end
    return want_rem ? r : q;
  endfunction

  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    logic [63:0] r;
    r = raw(!op[0], op[2], a, b, op[1]);
    return op[2] ? {{32{r[31]}}, r[31:0]} : r;
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [63:0] a,
                                    input logic [63:0] b);
    if (op[2])
      return (b[31:0] == 32'h0) ||
             (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return (b == 64'h0) ||
           (!op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
  endfunction

  // Behavioural divider: busy for lat+1 cycles after a handshake, then a one-cycle pulse.
  logic        busy;
  int          cnt;
  int          lat = 2;
  logic [63:0] m_a, m_b;
  logic        m_w, m_s;

  assign div_ready = !busy;

  always @(posedge clk) begin
    div_out_valid <= 1'b0;
    if (rst || div_flush) begin
      busy <= 1'b0;
    end else if (busy) begin
      if (cnt == 0) begin
        busy          <= 1'b0;
        div_out_valid <= 1'b1;
        div_quotient  <= raw(m_s, m_w, m_a, m_b, 1'b0);
        div_remainder <= raw(m_s, m_w, m_a, m_b, 1'b1);
      end else begin
        cnt <= cnt - 1;
      end
    end else if (div_valid && div_ready) begin
      busy <= 1'b1;
      cnt  <= lat;
      m_a  <= div_dividend;
      m_b  <= div_divisor;
      m_w  <= div_divw;
      m_s  <= div_signed;
    end
  end

  int hs_cnt = 0, dv_cnt = 0, fl_cnt = 0, ov_cnt = 0;
  always @(posedge clk) begin
    if (!rst) begin
      if (div_valid && div_ready) hs_cnt <= hs_cnt + 1;
      if (div_valid)              dv_cnt <= dv_cnt + 1;
      if (div_flush)              fl_cnt <= fl_cnt + 1;
      if (out_valid)              ov_cnt <= ov_cnt + 1;
    end
  end

  bit          cm_v = 1'b0;
  logic [63:0] cm_a, cm_b;
  logic        cm_u, cm_w;

  // Called at a negedge; returns at a negedge with the unit back in IDLE.
  task automatic run_op(input string name, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int hold);
    int hs0, dv0, cyc;
    bit fast, spec;
    logic [63:0] want;
    spec = is_special(op, a, b);
    fast = spec;
`ifdef DIV_RESULT_CACHE_EN
    if (cm_v && cm_a == a && cm_b == b && cm_u == op[0] && cm_w == op[2]) fast = 1'b1;
`endif
    sbq.push_back(exp);
    hs0 = hs_cnt;
    dv0 = dv_cnt;
    out_ready = (hold == 0);
    div_op = op; src1 = a; src2 = b; in_valid = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 50) begin @(negedge clk); cyc++; end
    check({name, ".in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 200) begin @(negedge clk); cyc++; end
    check({name, ".out_valid"}, 64'(out_valid), 64'd1);
    if (fast) check({name, ".latency"}, 64'(cyc), 64'd1);
    want = (sbq.size() > 0) ? sbq.pop_front() : 64'hx;
    check({name, ".result"}, result, want);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, ".hold_valid"}, 64'(out_valid), 64'd1);
      check({name, ".hold_result"}, result, want);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({name, ".release"}, 64'(out_valid), 64'd0);
    check({name, ".handshakes"}, 64'(hs_cnt - hs0), fast ? 64'd0 : 64'd1);
    if (fast) check({name, ".div_valid_cycles"}, 64'(dv_cnt - dv0), 64'd0);
    if (!spec) begin
      cm_v = 1'b1; cm_a = a; cm_b = b; cm_u = op[0]; cm_w = op[2];
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          hold;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0, fl0, ov0, cyc;
    logic [2:0]  rop;
    logic [63:0] ra, rb;

    tbl[0]  = '{3'b000, 64'd100, 64'd7, 64'd14, 0};
    tbl[1]  = '{3'b010, 64'd100, 64'd7, 64'd2, 0};
    tbl[2]  = '{3'b000, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0};
    tbl[3]  = '{3'b010, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0};
    tbl[4]  = '{3'b001, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0};
    tbl[5]  = '{3'b011, 64'h1234, 64'd0, 64'h1234, 0};
    tbl[6]  = '{3'b000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0};
    tbl[7]  = '{3'b010, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0};
    tbl[8]  = '{3'b100, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0};
    tbl[9]  = '{3'b101, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5};
    tbl[10] = '{3'b110, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0, 0};
    tbl[11] = '{3'b111, 64'h0000_0000_8000_0005, 64'h7700_0000_0000_0000, 64'hFFFF_FFFF_8000_0005, 0};
    tbl[12] = '{3'b100, 64'hABCD_0000_FFFF_FFF9, 64'h1234_5678_0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 0};
    tbl[13] = '{3'b111, 64'h0000_0000_FFFF_FFFF, 64'h10, 64'hF, 0};

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    div_op = 3'b000; src1 = '0; src2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.div_valid", 64'(div_valid), 64'd0);
    check("reset.div_flush", 64'(div_flush), 64'd0);
    check("reset.result", result, 64'd0);
    check("reset.in_ready", 64'(in_ready), 64'd1);

    foreach (tbl[i])
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].hold);

    for (int i = 0; i < 16; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = {$urandom, $urandom};
      rb  = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(1, 100)) : {$urandom, $urandom};
      if (rop[2] && rb[31:0] == 32'h0) rb[0] = 1'b1;
      lat = $urandom_range(0, 4);
      run_op($sformatf("rnd%0d", i), rop, ra, rb, ref_res(rop, ra, rb), 0);
    end

    // Flush an op sitting in WAIT: divider cancelled once, no result escapes.
    lat = 20;
    hs0 = hs_cnt; fl0 = fl_cnt; ov0 = ov_cnt;
    div_op = 3'b000; src1 = 64'd1000; src2 = 64'd3; in_valid = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 50) begin @(negedge clk); cyc++; end
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (hs_cnt == hs0 && cyc < 20) begin @(negedge clk); cyc++; end
    check("flush.handshake", 64'(hs_cnt - hs0), 64'd1);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush.div_flush_comb", 64'(div_flush), 64'd1);
    check("flush.in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    repeat (25) @(negedge clk);
    check("flush.div_flush_pulses", 64'(fl_cnt - fl0), 64'd1);
    check("flush.no_out_valid", 64'(ov_cnt - ov0), 64'd0);
    check("flush.idle", 64'(in_ready), 64'd1);
    lat = 2;

    run_op("post_flush_div", 3'b000, 64'd100, 64'd7, 64'd14, 0);
`ifdef DIV_RESULT_CACHE_EN
    run_op("cache_rem", 3'b010, 64'd100, 64'd7, 64'd2, 0);
`endif

    check("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
